// File: rtl/touch_adc_pkg.sv
// ---------------------------------------------------------------------------
// touch_adc_pkg
// Shared definitions for the resistive-touch ADC responder model:
//   - FSM state encoding (IDLE/CMD/BUSY/DATA/TAIL)
//   - channel address codes carried in control byte bits [6:4]
//   - control byte length and reduced-resolution word width
// ---------------------------------------------------------------------------
package touch_adc_pkg;

  typedef enum logic [2:0] {
    ST_IDLE = 3'd0,
    ST_CMD  = 3'd1,
    ST_BUSY = 3'd2,
    ST_DATA = 3'd3,
    ST_TAIL = 3'd4
  } state_t;

  localparam logic [2:0] CH_X  = 3'b101;
  localparam logic [2:0] CH_Y  = 3'b001;
  localparam logic [2:0] CH_Z1 = 3'b011;

  localparam int CMD_BITS     = 8;
  // Word width returned when the MODE bit selects reduced resolution
  localparam int LOW_RES_BITS = 8;

endpackage

// File: rtl/touch_sig_sync.sv
// ---------------------------------------------------------------------------
// touch_sig_sync
// Multi-flop synchronizer for one asynchronous input plus rise/fall detect
// on the synchronized level. Everything is clocked by cclk.
// Ports:
//   cclk   in   system clock
//   rstb   in   asynchronous active-low reset
//   raw    in   asynchronous input
//   level  out  synchronized level (STAGES flops after raw)
//   rise   out  1-cclk pulse when level goes 0->1
//   fall   out  1-cclk pulse when level goes 1->0
// Parameters:
//   STAGES   synchronizer depth, 2..4
//   RST_VAL  value the chain resets to (idle level of the input)
// ---------------------------------------------------------------------------
module touch_sig_sync #(
  parameter int   STAGES  = 2,
  parameter logic RST_VAL = 1'b0
) (
  input  logic cclk,
  input  logic rstb,
  input  logic raw,
  output logic level,
  output logic rise,
  output logic fall
);

  logic [STAGES-1:0] chain_reg;
  logic              prev_reg;

  always_ff @(posedge cclk or negedge rstb) begin
    if (!rstb) begin
      chain_reg <= {STAGES{RST_VAL}};
      prev_reg  <= RST_VAL;
    end else begin
      chain_reg <= {chain_reg[STAGES-2:0], raw};
      prev_reg  <= chain_reg[STAGES-1];
    end
  end

  assign level = chain_reg[STAGES-1];
  assign rise  = level & ~prev_reg;
  assign fall  = ~level & prev_reg;

endmodule

// File: rtl/touch_adc_responder.sv
// ---------------------------------------------------------------------------
// touch_adc_responder
// SPI responder model of a resistive-touch ADC. Decodes 8-bit control bytes
// shifted in on touch_data_in (sampled on DCLK rise) and returns a 12-bit or
// 8-bit conversion word on touch_data_out (updated on DCLK fall), after a
// one-DCLK busy gap. Channel values come from the x/y/z fabric inputs.
// Ports:
//   cclk, rstb           system clock, asynchronous active-low reset
//   touch_clk            DCLK from initiator (async, half-period >= 4 cclk)
//   touch_csb            chip select, active-low
//   touch_data_in        DIN
//   touch_data_out       DOUT
//   touch_busy           BUSY flag
//   x_val, y_val, z_val  channel values for X, Y, Z1
//   cmd_strobe           1-cclk pulse when a control byte completes
//   cmd_byte             last completed control byte
//   conv_count           completed conversions (wraps)
// Configuration macro:
//   TOUCH_ADC_RESP_BUSY_EN  defined: touch_busy pulses for one DCLK period.
//                           undefined: touch_busy stays 0; the busy gap in
//                           the DOUT timing is kept.
// ---------------------------------------------------------------------------
module touch_adc_responder
  import touch_adc_pkg::*;
#(
  parameter int SYNC_STAGES = 2,
  parameter int DATA_BITS   = 12
) (
  input  logic                 cclk,
  input  logic                 rstb,
  input  logic                 touch_clk,
  input  logic                 touch_csb,
  input  logic                 touch_data_in,
  output logic                 touch_data_out,
  output logic                 touch_busy,
  input  logic [DATA_BITS-1:0] x_val,
  input  logic [DATA_BITS-1:0] y_val,
  input  logic [DATA_BITS-1:0] z_val,
  output logic                 cmd_strobe,
  output logic [7:0]           cmd_byte,
  output logic [15:0]          conv_count
);

  localparam int CNT_W = $clog2((DATA_BITS > CMD_BITS) ? DATA_BITS : CMD_BITS);
  localparam logic [CNT_W-1:0] CMD_LAST  = CNT_W'(CMD_BITS - 1);
  localparam logic [CNT_W-1:0] LAST_FULL = CNT_W'(DATA_BITS - 1);
  localparam logic [CNT_W-1:0] LAST_LOW  = CNT_W'(LOW_RES_BITS - 1);

`ifdef TOUCH_ADC_RESP_BUSY_EN
  localparam logic BUSY_LEVEL = 1'b1;
`else
  localparam logic BUSY_LEVEL = 1'b0;
`endif

  // Index 0: DCLK, 1: chip select, 2: DIN. All three see the same depth so
  // DIN stays aligned with the DCLK edge that samples it.
  logic [2:0] raw_vec, level_vec, rise_vec, fall_vec;
  assign raw_vec = {touch_data_in, touch_csb, touch_clk};

  genvar gi;
  generate
    for (gi = 0; gi < 3; gi++) begin : g_sync
      touch_sig_sync #(
        .STAGES  (SYNC_STAGES),
        .RST_VAL ((gi == 1) ? 1'b1 : 1'b0)
      ) u_sync (
        .cclk  (cclk),
        .rstb  (rstb),
        .raw   (raw_vec[gi]),
        .level (level_vec[gi]),
        .rise  (rise_vec[gi]),
        .fall  (fall_vec[gi])
      );
    end
  endgenerate

  logic clk_rise, clk_fall, csb_level, din_level;
  assign clk_rise  = rise_vec[0];
  assign clk_fall  = fall_vec[0];
  assign csb_level = level_vec[1];
  assign din_level = level_vec[2];

  logic unused_edges;
  assign unused_edges = ^{rise_vec[2:1], fall_vec[2:1], level_vec[0]};

  state_t                 state_reg, state_next;
  logic [CNT_W-1:0]       bit_cnt_reg, bit_cnt_next;
  logic [CMD_BITS-1:0]    cmd_shift_reg, cmd_shift_next;
  logic [DATA_BITS-1:0]   data_shift_reg, data_shift_next;
  logic                   mode8_reg, mode8_next;
  logic                   dout_reg, dout_next;
  logic                   busy_reg, busy_next;
  logic                   strobe_reg, strobe_next;
  logic [7:0]             cmd_byte_reg, cmd_byte_next;
  logic [15:0]            conv_count_reg, conv_count_next;

  // Control byte as it stands including the bit arriving on this rise
  logic [CMD_BITS-1:0]    cmd_word;
  logic [DATA_BITS-1:0]   snapshot;
  logic [DATA_BITS-1:0]   low_res_word;

  assign cmd_word = {cmd_shift_reg[CMD_BITS-2:0], din_level};

  always_comb begin
    snapshot = '0;
    case (cmd_word[6:4])
      CH_X:    snapshot = x_val;
      CH_Y:    snapshot = y_val;
      CH_Z1:   snapshot = z_val;
      default: snapshot = '0;
    endcase
  end

  // Reduced resolution: top bits left-aligned so the same MSB-first shifter
  // serves both modes.
  assign low_res_word = {snapshot[DATA_BITS-1 -: LOW_RES_BITS],
                         {(DATA_BITS-LOW_RES_BITS){1'b0}}};

  always_comb begin
    state_next      = state_reg;
    bit_cnt_next    = bit_cnt_reg;
    cmd_shift_next  = cmd_shift_reg;
    data_shift_next = data_shift_reg;
    mode8_next      = mode8_reg;
    dout_next       = dout_reg;
    busy_next       = busy_reg;
    strobe_next     = 1'b0;
    cmd_byte_next   = cmd_byte_reg;
    conv_count_next = conv_count_reg;

    if (csb_level) begin
      state_next   = ST_IDLE;
      dout_next    = 1'b0;
      busy_next    = 1'b0;
      bit_cnt_next = '0;
    end else begin
      unique case (state_reg)
        ST_IDLE, ST_TAIL: begin
          dout_next = 1'b0;
          busy_next = 1'b0;
          // Leading zeros are ignored; the first 1 is the start bit
          if (clk_rise && din_level) begin
            state_next     = ST_CMD;
            bit_cnt_next   = CNT_W'(1);
            cmd_shift_next = {{(CMD_BITS-1){1'b0}}, 1'b1};
          end
        end
        ST_CMD: begin
          if (clk_rise) begin
            if (bit_cnt_reg == CMD_LAST) begin
              cmd_byte_next   = cmd_word;
              strobe_next     = 1'b1;
              mode8_next      = cmd_word[3];
              data_shift_next = cmd_word[3] ? low_res_word : snapshot;
              bit_cnt_next    = '0;
              state_next      = ST_BUSY;
            end else begin
              cmd_shift_next = cmd_word;
              bit_cnt_next   = bit_cnt_reg + 1'b1;
            end
          end
        end
        ST_BUSY: begin
          // bit_cnt_reg doubles as the fall counter: 0 = busy fall pending
          if (clk_fall) begin
            if (bit_cnt_reg == '0) begin
              busy_next    = BUSY_LEVEL;
              dout_next    = 1'b0;
              bit_cnt_next = CNT_W'(1);
            end else begin
              busy_next       = 1'b0;
              dout_next       = data_shift_reg[DATA_BITS-1];
              data_shift_next = {data_shift_reg[DATA_BITS-2:0], 1'b0};
              bit_cnt_next    = mode8_reg ? LAST_LOW : LAST_FULL;
              state_next      = ST_DATA;
            end
          end
        end
        ST_DATA: begin
          // bit_cnt_reg = bits still to send after the one on dout
          if (clk_fall) begin
            if (bit_cnt_reg != '0) begin
              dout_next       = data_shift_reg[DATA_BITS-1];
              data_shift_next = {data_shift_reg[DATA_BITS-2:0], 1'b0};
              bit_cnt_next    = bit_cnt_reg - 1'b1;
            end else begin
              dout_next       = 1'b0;
              conv_count_next = conv_count_reg + 16'd1;
              state_next      = ST_TAIL;
            end
          end
        end
        default: state_next = ST_IDLE;
      endcase
    end
  end

  always_ff @(posedge cclk or negedge rstb) begin
    if (!rstb) begin
      state_reg      <= ST_IDLE;
      bit_cnt_reg    <= '0;
      cmd_shift_reg  <= '0;
      data_shift_reg <= '0;
      mode8_reg      <= 1'b0;
      dout_reg       <= 1'b0;
      busy_reg       <= 1'b0;
      strobe_reg     <= 1'b0;
      cmd_byte_reg   <= '0;
      conv_count_reg <= '0;
    end else begin
      state_reg      <= state_next;
      bit_cnt_reg    <= bit_cnt_next;
      cmd_shift_reg  <= cmd_shift_next;
      data_shift_reg <= data_shift_next;
      mode8_reg      <= mode8_next;
      dout_reg       <= dout_next;
      busy_reg       <= busy_next;
      strobe_reg     <= strobe_next;
      cmd_byte_reg   <= cmd_byte_next;
      conv_count_reg <= conv_count_next;
    end
  end

  assign touch_data_out = dout_reg;
  assign touch_busy     = busy_reg;
  assign cmd_strobe     = strobe_reg;
  assign cmd_byte       = cmd_byte_reg;
  assign conv_count     = conv_count_reg;

endmodule

// File: tb/tb_touch_adc_responder.sv
`timescale 1ns/1ps
module tb_touch_adc_responder;

  localparam int SYNC_STAGES = 2;
  localparam int HALF        = 60;   // DCLK half-period: 6 cclk
`ifdef TOUCH_ADC_RESP_BUSY_EN
  localparam logic BUSY_EXP = 1'b1;
`else
  localparam logic BUSY_EXP = 1'b0;
`endif

  logic        cclk = 1'b0;
  logic        rstb;
  logic        touch_clk, touch_csb, touch_data_in;
  logic        touch_data_out, touch_busy;
  logic [11:0] x_val, y_val, z_val;
  logic        cmd_strobe;
  logic [7:0]  cmd_byte;
  logic [15:0] conv_count;

  touch_adc_responder #(.SYNC_STAGES(SYNC_STAGES), .DATA_BITS(12)) dut (
    .cclk           (cclk),
    .rstb           (rstb),
    .touch_clk      (touch_clk),
    .touch_csb      (touch_csb),
    .touch_data_in  (touch_data_in),
    .touch_data_out (touch_data_out),
    .touch_busy     (touch_busy),
    .x_val          (x_val),
    .y_val          (y_val),
    .z_val          (z_val),
    .cmd_strobe     (cmd_strobe),
    .cmd_byte       (cmd_byte),
    .conv_count     (conv_count)
  );

  always #5 cclk = ~cclk;

  typedef struct {
    string       name;
    logic [15:0] act;
    logic [15:0] exp;
  } chk_t;

  chk_t        chk_q[$];        // direct observations with their expectations
  logic [7:0]  exp_cmd_q[$];    // expected cmd_byte per strobe
  logic [15:0] exp_cnt_q[$];    // expected conv_count per change
  logic [14:0] exp_word_q[$];   // expected DOUT stream, rises 9..23
  logic [14:0] rx_q[$];         // observed DOUT stream, rises 9..23

  int          n_cmp = 0;
  int          n_fail = 0;
  logic [15:0] last_cc = 16'd0;
  logic [15:0] exp_count = 16'd0;

  task automatic compare(input string name, input logic [15:0] act, input logic [15:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end else begin
      $display("ok   %s: 0x%0h", name, act);
    end
  endtask

  // Single checking process: drains observations and watches DUT outputs
  always @(negedge cclk) begin
    chk_t        c;
    logic [14:0] rw;
    logic [14:0] ew;
    while (chk_q.size() > 0) begin
      c = chk_q.pop_front();
      compare(c.name, c.act, c.exp);
    end
    if (cmd_strobe) begin
      compare("strobe_pending", 16'(exp_cmd_q.size()), 16'd1);
      if (exp_cmd_q.size() > 0) compare("cmd_byte", {8'h00, cmd_byte}, {8'h00, exp_cmd_q.pop_front()});
    end
    if (conv_count != last_cc) begin
      compare("count_pending", 16'(exp_cnt_q.size()), 16'd1);
      if (exp_cnt_q.size() > 0) compare("conv_count", conv_count, exp_cnt_q.pop_front());
      last_cc = conv_count;
    end
    while (rx_q.size() > 0) begin
      rw = rx_q.pop_front();
      ew = (exp_word_q.size() > 0) ? exp_word_q.pop_front() : 15'h7FFF;
      compare("dout_stream", {1'b0, rw}, {1'b0, ew});
    end
  end

  task automatic push_chk(input string n, input logic [15:0] a, input logic [15:0] e);
    chk_t c;
    c.name = n;
    c.act  = a;
    c.exp  = e;
    chk_q.push_back(c);
  endtask

  // One DCLK period: DIN set while DCLK low, DOUT/BUSY sampled just before rise
  task automatic spi_clock(input logic din, output logic dv, output logic bv);
    touch_data_in = din;
    #(HALF);
    dv = touch_data_out;
    bv = touch_busy;
    touch_clk = 1'b1;
    #(HALF);
    touch_clk = 1'b0;
  endtask

  // Full 24-DCLK frame; optional leading zeros and a mid-DATA x_val change
  task automatic run_frame(input logic [7:0] cmd, input int nlead, input logic [11:0] word,
                           input int x_change_k, input logic [11:0] new_x);
    logic [14:0] rx;
    logic        dv, bv, din;
    rx = '0;
    exp_count = exp_count + 16'd1;
    exp_cmd_q.push_back(cmd);
    exp_cnt_q.push_back(exp_count);
    exp_word_q.push_back({1'b0, word, 2'b00});
    touch_csb = 1'b0;
    #(HALF);
    for (int i = 0; i < nlead; i++) spi_clock(1'b0, dv, bv);
    for (int k = 1; k <= 24; k++) begin
      din = (k <= 8) ? cmd[8-k] : 1'b0;
      spi_clock(din, dv, bv);
      if (k == 9)  push_chk("busy_phase", {15'd0, bv}, {15'd0, BUSY_EXP});
      if (k == 10) push_chk("busy_release", {15'd0, bv}, 16'd0);
      if (k >= 9 && k <= 23) rx[23-k] = dv;
      if (k == x_change_k) x_val = new_x;
    end
    rx_q.push_back(rx);
    touch_csb = 1'b1;
    #(2*HALF);
  endtask

  initial begin
    logic       dv, bv;
    logic [7:0] cmd;
    rstb = 1'b0; touch_clk = 1'b0; touch_csb = 1'b1; touch_data_in = 1'b0;
    x_val = 12'hABC; y_val = 12'h123; z_val = 12'h5A5;
    #25;
    push_chk("reset_dout_busy_strobe", {13'd0, touch_data_out, touch_busy, cmd_strobe}, 16'd0);
    push_chk("reset_cmd_byte", {8'h00, cmd_byte}, 16'd0);
    push_chk("reset_conv_count", conv_count, 16'd0);
    #15 rstb = 1'b1;
    #100;

    // 1: X channel, 12-bit
    run_frame(8'hD0, 0, 12'hABC, 0, 12'h000);
    // 2: Y channel, unmapped address, Z1 channel
    run_frame(8'h90, 0, 12'h123, 0, 12'h000);
    run_frame(8'hA0, 0, 12'h000, 0, 12'h000);
    run_frame(8'hB0, 0, 12'h5A5, 0, 12'h000);
    // 3: 8-bit mode returns the top byte then zeros
    run_frame(8'hD8, 0, 12'hAB0, 0, 12'h000);

    // 4: chip select raised after 5 data bits
    x_val = 12'hFFF;
    cmd = 8'hD0;
    exp_cmd_q.push_back(cmd);
    touch_csb = 1'b0;
    #(HALF);
    for (int k = 1; k <= 14; k++) spi_clock((k <= 8) ? cmd[8-k] : 1'b0, dv, bv);
    #30;
    push_chk("abort_pre_dout", {15'd0, touch_data_out}, 16'd1);
    touch_csb = 1'b1;
    #((1 + SYNC_STAGES) * 10 + 5);
    push_chk("abort_dout_busy", {14'd0, touch_data_out, touch_busy}, 16'd0);
    push_chk("abort_count_held", conv_count, exp_count);
    #(2*HALF);
    x_val = 12'hABC;
    run_frame(8'hD0, 0, 12'hABC, 0, 12'h000);

    // 5: leading zeros, then x_val changed while data is in flight
    run_frame(8'hD0, 3, 12'hABC, 15, 12'h555);
    x_val = 12'hABC;

    // 6: reset in the middle of the control byte
    touch_csb = 1'b0;
    #(HALF);
    for (int k = 1; k <= 4; k++) spi_clock(cmd[8-k], dv, bv);
    exp_count = 16'd0;
    exp_cnt_q.push_back(16'd0);
    rstb = 1'b0;
    #1;
    push_chk("midreset_dout_busy_strobe", {13'd0, touch_data_out, touch_busy, cmd_strobe}, 16'd0);
    push_chk("midreset_cmd_byte", {8'h00, cmd_byte}, 16'd0);
    push_chk("midreset_conv_count", conv_count, 16'd0);
    touch_csb = 1'b1;
    #39 rstb = 1'b1;
    #100;
    run_frame(8'hD0, 0, 12'hABC, 0, 12'h000);

    #200;
    push_chk("left_cmd", 16'(exp_cmd_q.size()), 16'd0);
    push_chk("left_count", 16'(exp_cnt_q.size()), 16'd0);
    push_chk("left_word", 16'(exp_word_q.size()), 16'd0);
    repeat (3) @(negedge cclk);
    #1;
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
